dma_stream_packer: RTL and testbench
====================================

// Module: dma_stream_packer
// PURPOSE
//  Upstream feeder for the DMA block in stream-read mode. Packs narrow ADC/correlator samples into AXI_WIDTH words.
//  Buffers the words in a FIFO and presents them as an AXI3 R-channel-style stream (rdata/rvalid/rready).
//  Raises a stretched irq pulse each time BLOCK_LEN words have been produced, which triggers the DMA.
// PARAMETERS
//  AXI_WIDTH     32   output word width; must equal DMA AXI_WIDTH
//  SAMPLE_WIDTH  8    input sample width; AXI_WIDTH/SAMPLE_WIDTH must be a power of 2, >=1
//  FIFO_AWIDTH   5    FIFO depth = 2**FIFO_AWIDTH words
//  BLOCK_LEN     256  words per irq block, >=1, < 2**16
//  IRQ_LEN       8    irq high time in clk cycles, >=2 (covers DMA irq synchroniser)
// PORTS
//  clk       in   1              clock
//  resetn    in   1              asynchronous reset, active low
//  en        in   1              capture enable
//  clr       in   1              one-cycle pulse: clear overflow and block counter
//  in_data   in   SAMPLE_WIDTH   input sample
//  in_valid  in   1              in_data valid this cycle
//  rdata     out  AXI_WIDTH      FIFO head word
//  rvalid    out  1              FIFO not empty
//  rready    in   1              consumer accepts rdata
//  irq       out  1              block-ready pulse, IRQ_LEN cycles
//  overflow  out  1              sticky: a packed word was dropped
//  level     out  FIFO_AWIDTH+1  words currently in FIFO
// BEHAVIOUR
//  Reset (resetn=0): FIFO empty, pack/block/irq counters 0; rvalid=0, rdata=0, irq=0, overflow=0, level=0.
//  Packing (SPW = AXI_WIDTH/SAMPLE_WIDTH):
//   - Sample k of a word lands in bits [k*SAMPLE_WIDTH +: SAMPLE_WIDTH]; first sample goes to the LSBs.
//   - in_valid & en advances the pack counter (0..SPW-1).
//   - On the SPW-th sample the completed word (including the current sample) is pushed the same cycle.
//     The pack counter wraps to 0.
//   - en=0: the pack counter clears to 0 and any partial word is discarded. FIFO contents are kept and continue to drain.
//   - SPW=1: every valid sample pushes one word.
//  FIFO:
//   - First-word-fall-through: a word pushed at edge N gives rvalid=1 and rdata=word after edge N.
//   - Pop on rvalid & rready. rdata is held stable while rvalid & !rready.
//   - Push is accepted if level < 2**FIFO_AWIDTH, or if a pop occurs in the same cycle.
//   - A refused push drops the word and sets overflow (sticky). The pack counter wraps normally.
//   - Simultaneous push and pop: level is unchanged. Pointers wrap modulo depth.
//   - When the FIFO is empty, rdata keeps its last value; rvalid=0.
//  Block counter:
//   - Counts accepted pushes only (dropped words are not counted).
//   - On reaching BLOCK_LEN it wraps to 0 and loads the irq counter with IRQ_LEN.
//   - irq is asserted the cycle after the block-completing push and stays high while the irq counter is non-zero.
//   - A block completing while irq is high reloads the counter; irq stays high with no new edge (the blocks merge).
//  clr: clears overflow, the block counter and the irq counter next edge.
//   - It has priority over a same-cycle set or increment.
//   - It does not touch the FIFO or the pack counter.
//  Width rules: level = wr_ptr - rd_ptr in FIFO_AWIDTH+1 bits; the block counter is $clog2(BLOCK_LEN+1) bits.
//  Reset mid-operation: all state returns to reset values immediately. Partially packed and buffered data are lost.
// TESTING
//  - SW=8, AXI=32, en=1, samples 0x01..0x08 back-to-back, rready=1 -> rdata 0x04030201 then 0x08070605, each rvalid 1 cycle after 4th/8th sample.
//  - rready=0, push 2**FIFO_AWIDTH+1 words -> level=32, 33rd word dropped, overflow=1; drain -> 32 words in order, no gaps.
//  - Full FIFO, push and pop in the same cycle -> push accepted, level stays 32, overflow stays 0.
//  - BLOCK_LEN=4, 12 words continuous -> 3 irq pulses of 8 cycles each, rising 1 cycle after the 4th/8th/12th push.
//  - BLOCK_LEN=1, a word every 4 cycles -> irq stays continuously high (merged); clr -> irq=0 next cycle, overflow=0.
//  - 2 samples then en=0 for 1 cycle, then 4 samples -> exactly one word, built from the last 4 samples; resetn low mid-burst -> rvalid=0, level=0.

Source files
------------

// File: rtl/dma_stream_packer.sv
// Packs narrow samples into AXI_WIDTH words, buffers them in a first-word-fall-through
// FIFO and raises a stretched block-ready irq every BLOCK_LEN accepted words.
module dma_stream_packer #(
  parameter int AXI_WIDTH    = 32,
  parameter int SAMPLE_WIDTH = 8,
  parameter int FIFO_AWIDTH  = 5,
  parameter int BLOCK_LEN    = 256,
  parameter int IRQ_LEN      = 8
) (
  input  logic                    clk,
  input  logic                    resetn,
  input  logic                    en,
  input  logic                    clr,
  input  logic [SAMPLE_WIDTH-1:0] in_data,
  input  logic                    in_valid,
  output logic [AXI_WIDTH-1:0]    rdata,
  output logic                    rvalid,
  input  logic                    rready,
  output logic                    irq,
  output logic                    overflow,
  output logic [FIFO_AWIDTH:0]    level
);

  localparam int SPW   = AXI_WIDTH / SAMPLE_WIDTH;
  localparam int PCW   = (SPW > 1) ? $clog2(SPW) : 1;
  localparam int DEPTH = 1 << FIFO_AWIDTH;
  localparam int LW    = FIFO_AWIDTH + 1;
  localparam int BCW   = $clog2(BLOCK_LEN + 1);
  localparam int ICW   = $clog2(IRQ_LEN + 1);

  logic [PCW-1:0]         pack_cnt;
  logic [AXI_WIDTH-1:0]   pack_word;
  logic [AXI_WIDTH-1:0]   word_next;
  logic [AXI_WIDTH-1:0]   mem [DEPTH];
  logic [LW-1:0]          wr_ptr;
  logic [LW-1:0]          rd_ptr;
  logic [LW-1:0]          level_next;
  logic [FIFO_AWIDTH-1:0] rd_idx_next;
  logic [BCW-1:0]         blk_cnt;
  logic [ICW-1:0]         irq_cnt;
  logic [ICW-1:0]         irq_cnt_next;
  logic                   push;
  logic                   pop;
  logic                   push_ok;
  logic                   blk_done;

  // Word assembly, push/pop qualification and next-state helpers
  always_comb begin
    word_next = pack_word;
    word_next[pack_cnt*SAMPLE_WIDTH +: SAMPLE_WIDTH] = in_data;
    push        = en & in_valid & (pack_cnt == PCW'(SPW - 1));
    pop         = rvalid & rready;
    push_ok     = push & ((level < LW'(DEPTH)) | pop);
    blk_done    = push_ok & (blk_cnt == BCW'(BLOCK_LEN - 1));
    level_next  = level + LW'(push_ok) - LW'(pop);
    rd_idx_next = rd_ptr[FIFO_AWIDTH-1:0] + FIFO_AWIDTH'(1);
    if (blk_done) begin
      irq_cnt_next = ICW'(IRQ_LEN);
    end else if (irq_cnt != ICW'(0)) begin
      irq_cnt_next = irq_cnt - ICW'(1);
    end else begin
      irq_cnt_next = ICW'(0);
    end
  end

  // Pack counter and partial word; dropping en discards the partial word
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      pack_cnt  <= PCW'(0);
      pack_word <= AXI_WIDTH'(0);
    end else if (!en) begin
      pack_cnt  <= PCW'(0);
      pack_word <= AXI_WIDTH'(0);
    end else if (in_valid) begin
      if (push) begin
        pack_cnt  <= PCW'(0);
        pack_word <= AXI_WIDTH'(0);
      end else begin
        pack_cnt  <= pack_cnt + PCW'(1);
        pack_word <= word_next;
      end
    end
  end

  // FIFO storage
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wr_ptr[FIFO_AWIDTH-1:0]] <= word_next;
    end
  end

  // FIFO pointers and the registered head word; an empty FIFO holds its last rdata
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr <= LW'(0);
      rd_ptr <= LW'(0);
      level  <= LW'(0);
      rvalid <= 1'b0;
      rdata  <= AXI_WIDTH'(0);
    end else begin
      wr_ptr <= wr_ptr + LW'(push_ok);
      rd_ptr <= rd_ptr + LW'(pop);
      level  <= level_next;
      rvalid <= (level_next != LW'(0));
      if (pop) begin
        if (level > LW'(1)) begin
          rdata <= mem[rd_idx_next];
        end else if (push_ok) begin
          rdata <= word_next;
        end
      end else if ((level == LW'(0)) && push_ok) begin
        rdata <= word_next;
      end
    end
  end

  // Block counter, irq stretcher and sticky overflow; clr wins over any update
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      blk_cnt  <= BCW'(0);
      irq_cnt  <= ICW'(0);
      irq      <= 1'b0;
      overflow <= 1'b0;
    end else if (clr) begin
      blk_cnt  <= BCW'(0);
      irq_cnt  <= ICW'(0);
      irq      <= 1'b0;
      overflow <= 1'b0;
    end else begin
      if (blk_done) begin
        blk_cnt <= BCW'(0);
      end else if (push_ok) begin
        blk_cnt <= blk_cnt + BCW'(1);
      end
      irq_cnt <= irq_cnt_next;
      irq     <= (irq_cnt_next != ICW'(0));
      if (push & ~push_ok) begin
        overflow <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_dma_stream_packer.sv
// Bench for dma_stream_packer: directed scenarios plus random traffic, checked every
// cycle against a queue-based reference model; u0 uses BLOCK_LEN=4, u1 BLOCK_LEN=1.
module tb_dma_stream_packer;

  localparam int SPW     = 4;
  localparam int DEPTH   = 32;
  localparam int IRQ_LEN = 8;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        en = 1'b0;
  logic        clr = 1'b0;
  logic        in_valid = 1'b0;
  logic        rready = 1'b0;
  logic [7:0]  in_data = 8'h00;
  logic [31:0] rdata0, rdata1;
  logic        rvalid0, rvalid1, irq0, irq1, ovf0, ovf1;
  logic [5:0]  level0, level1;

  int vectors = 0;
  int miscompares = 0;

  logic [31:0] q[$];
  logic [7:0]  partial[$];
  logic [31:0] exp_rdata;
  bit          exp_ovf;
  int          bcnt[2];
  int          irqt[2];
  int          bl[2] = '{4, 1};

  dma_stream_packer #(.AXI_WIDTH(32), .SAMPLE_WIDTH(8), .FIFO_AWIDTH(5),
                      .BLOCK_LEN(4), .IRQ_LEN(IRQ_LEN)) u0 (
    .clk(clk), .resetn(resetn), .en(en), .clr(clr), .in_data(in_data),
    .in_valid(in_valid), .rdata(rdata0), .rvalid(rvalid0), .rready(rready),
    .irq(irq0), .overflow(ovf0), .level(level0));

  dma_stream_packer #(.AXI_WIDTH(32), .SAMPLE_WIDTH(8), .FIFO_AWIDTH(5),
                      .BLOCK_LEN(1), .IRQ_LEN(IRQ_LEN)) u1 (
    .clk(clk), .resetn(resetn), .en(en), .clr(clr), .in_data(in_data),
    .in_valid(in_valid), .rdata(rdata1), .rvalid(rvalid1), .rready(rready),
    .irq(irq1), .overflow(ovf1), .level(level1));

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    q.delete();
    partial.delete();
    exp_rdata = 32'h0;
    exp_ovf = 1'b0;
    for (int i = 0; i < 2; i++) begin
      bcnt[i] = 0;
      irqt[i] = 0;
    end
  endtask

  task automatic check_all();
    check("rvalid", rvalid0, 32'(q.size() > 0));
    check("rdata", rdata0, exp_rdata);
    check("level", level0, 32'(q.size()));
    check("overflow", ovf0, 32'(exp_ovf));
    check("irq_b4", irq0, 32'(irqt[0] > 0));
    check("irq_b1", irq1, 32'(irqt[1] > 0));
    check("rvalid_u1", rvalid1, 32'(q.size() > 0));
    check("level_u1", level1, 32'(q.size()));
    check("overflow_u1", ovf1, 32'(exp_ovf));
  endtask

  // One clock: advance the model with the pre-edge inputs, then compare after the edge
  task automatic tick();
    int          pre;
    bit          pop;
    bit          have;
    bit          acc;
    logic [31:0] w;
    pre  = q.size();
    pop  = (pre > 0) && rready;
    have = 1'b0;
    w    = 32'h0;
    if (!en) begin
      partial.delete();
    end else if (in_valid) begin
      partial.push_back(in_data);
      if (partial.size() == SPW) begin
        for (int k = 0; k < SPW; k++) w[k*8 +: 8] = partial[k];
        partial.delete();
        have = 1'b1;
      end
    end
    acc = have && ((pre < DEPTH) || pop);
    if (pop) void'(q.pop_front());
    if (acc) q.push_back(w);
    if (have && !acc) exp_ovf = 1'b1;
    for (int i = 0; i < 2; i++) begin
      if (irqt[i] > 0) irqt[i]--;
      if (acc) begin
        bcnt[i]++;
        if (bcnt[i] == bl[i]) begin
          bcnt[i] = 0;
          irqt[i] = IRQ_LEN;
        end
      end
    end
    if (clr) begin
      exp_ovf = 1'b0;
      for (int i = 0; i < 2; i++) begin
        bcnt[i] = 0;
        irqt[i] = 0;
      end
    end
    @(posedge clk);
    #1;
    if (q.size() > 0) exp_rdata = q[0];
    check_all();
  endtask

  task automatic put(input logic [7:0] d);
    en = 1'b1;
    in_valid = 1'b1;
    in_data = d;
    tick();
  endtask

  task automatic idle();
    in_valid = 1'b0;
    tick();
  endtask

  int   rises0, highs0, rises1;
  logic prev0, prev1;

  initial begin
    // Power-on reset
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_all();
    resetn = 1'b1;

    // Basic packing, LSB-first
    rready = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      put(8'(i));
      if (i == 4) begin
        check("word0_valid", rvalid0, 32'h1);
        check("word0", rdata0, 32'h04030201);
      end
      if (i == 8) begin
        check("word1_valid", rvalid0, 32'h1);
        check("word1", rdata0, 32'h08070605);
      end
    end
    idle();

    // Fill past full with the consumer stalled
    rready = 1'b0;
    for (int w = 0; w < DEPTH + 1; w++)
      for (int k = 0; k < SPW; k++) put(8'($urandom));
    check("full_level", level0, 32'd32);
    check("full_overflow", ovf0, 32'h1);

    // clr the sticky flag, then push and pop together on a full FIFO
    en = 1'b0;
    in_valid = 1'b0;
    clr = 1'b1;
    tick();
    clr = 1'b0;
    check("clr_overflow", ovf0, 32'h0);
    for (int k = 0; k < 3; k++) put(8'($urandom));
    rready = 1'b1;
    put(8'($urandom));
    check("pushpop_level", level0, 32'd32);
    check("pushpop_overflow", ovf0, 32'h0);
    en = 1'b0;
    in_valid = 1'b0;
    repeat (DEPTH + 2) tick();
    check("drained_level", level0, 32'd0);
    check("drained_rvalid", rvalid0, 32'h0);

    // Block irq: 12 words continuous
    clr = 1'b1;
    tick();
    clr = 1'b0;
    rises0 = 0; highs0 = 0; rises1 = 0;
    prev0 = irq0; prev1 = irq1;
    for (int n = 0; n < 48 + 20; n++) begin
      if (n < 48) put(8'($urandom));
      else idle();
      if (irq0 && !prev0) rises0++;
      if (irq0) highs0++;
      if (irq1 && !prev1) rises1++;
      prev0 = irq0;
      prev1 = irq1;
    end
    check("irq_pulses", 32'(rises0), 32'd3);
    check("irq_high_cycles", 32'(highs0), 32'd24);
    check("irq_merged_rises", 32'(rises1), 32'd1);

    // Merged irq on BLOCK_LEN=1 then clr
    for (int n = 0; n < 16; n++) put(8'($urandom));
    check("merged_irq_high", irq1, 32'h1);
    en = 1'b0;
    in_valid = 1'b0;
    clr = 1'b1;
    tick();
    clr = 1'b0;
    check("clr_irq", irq1, 32'h0);
    check("clr_overflow2", ovf1, 32'h0);

    // en drop discards a partial word
    rready = 1'b0;
    put(8'hA1);
    put(8'hA2);
    en = 1'b0;
    idle();
    put(8'hB1);
    put(8'hB2);
    put(8'hB3);
    put(8'hB4);
    idle();
    check("discard_level", level0, 32'd1);
    check("discard_word", rdata0, 32'hB4B3B2B1);

    // Reset mid-burst
    put(8'hC1);
    put(8'hC2);
    resetn = 1'b0;
    #1;
    check("rst_rvalid", rvalid0, 32'h0);
    check("rst_level", level0, 32'd0);
    model_reset();
    check_all();
    in_valid = 1'b0;
    en = 1'b0;
    @(posedge clk);
    #1;
    resetn = 1'b1;

    // Random traffic with varying consumer pressure
    for (int n = 0; n < 1200; n++) begin
      en       = ($urandom_range(0, 19) != 0);
      in_valid = ($urandom_range(0, 3) != 0);
      in_data  = 8'($urandom);
      if ((n / 200) % 2 == 0) rready = ($urandom_range(0, 3) != 0);
      else                    rready = ($urandom_range(0, 4) == 0);
      clr = ($urandom_range(0, 63) == 0);
      tick();
    end
    clr = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
